fp_add_seq: RTL
===============

// Module: fp_add_seq
// PURPOSE
//  Multi-cycle sequencer for single-precision FP addition built around the shared clz counter.
//  Accepts one operand pair, then steps ALIGN -> ADD -> NORM -> PACK, one stage per cycle.
//  Drives the clz instance during NORM and returns a packed IEEE-754 result over valid/ready.
//  Sits between the operand register file and the result writeback of the FP unit.
// PARAMETERS
//  EXP_W      8             exponent width; only 8 supported (clz input fixed at 24 bits)
//  FRAC_W     23            fraction width; only 23 supported
//  QNAN_VAL   32'h7FC00000  result returned when either operand has exponent 255
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   operand pair valid
//  in_ready   out  1   sequencer idle, can accept a pair
//  op_a       in   32  IEEE-754 operand A
//  op_b       in   32  IEEE-754 operand B
//  out_valid  out  1   result valid, held until taken
//  out_ready  in   1   consumer accepts result
//  result     out  32  IEEE-754 sum
//  ovf        out  1   result saturated to infinity (qualified by out_valid)
//  unf        out  1   result flushed to zero from nonzero sum (qualified by out_valid)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; in_ready=0 while rst_n=0, then 1; out_valid=0; result=0; ovf=unf=0.
//  Reset mid-operation aborts the operation; no output is produced.
//  FSM states: IDLE, ALIGN, ADD, NORM, PACK, DONE.
//   IDLE : in_ready=1; in_valid&in_ready -> register operands, go to ALIGN.
//   ALIGN: denormals (exp 0) are zeroed. Operands are ordered by magnitude: compare exp, then frac.
//          Shift the smaller 24-bit significand right by the exp difference; diff>=24 -> 0.
//          Shifted-out bits are truncated (round toward zero, no guard/sticky).
//   ADD  : same signs -> 25-bit sum; different signs -> larger minus smaller. Sign = larger operand's sign.
//   NORM : carry set -> shift right 1, exp+1. Sum==0 -> zero result; clz is not consulted.
//          Otherwise lz=clz(sum[23:0]), shift left lz, exp-lz (10-bit signed working exponent).
//   PACK : exp>=255 -> {sign,8'hFF,23'h0}, ovf=1. Exp<=0 with nonzero sum -> +0, unf=1.
//          Zero sum -> +0 (including x + -x). Either input exp==255 -> QNAN_VAL, no flags.
//   DONE : out_valid=1; result/flags stable; out_valid&out_ready -> IDLE.
//  Latency: accept edge N -> out_valid high after edge N+5 (ALIGN..PACK, then DONE).
//  Throughput: one operation in flight; in_ready=0 in every state except IDLE.
//  Result is taken in DONE, so in_ready rises the cycle after the handshake (no same-cycle re-accept).
//  Consumer backpressure (out_ready=0) holds DONE indefinitely with outputs unchanged.
//  in_valid while busy is ignored; op_a/op_b are sampled only on acceptance.
// STRUCTURE
//  Shared header fp_defs.vh: FSM state encodings, EXP_BIAS=127, EXP_MAX=255, QNAN constant, field slices.
//  One sub-module: existing clz (24-bit in, 5-bit out), instantiated once, fed from the NORM-stage sum.
//  Everything else (align shifter, adder, left shifter, packer) stays inline in fp_add_seq.
// TESTING
//  1) 3F800000 + 3F800000 -> 40000000, carry path; out_valid 5 edges after accept; ovf=unf=0.
//  2) 3FC00000 + BF800000 -> 3F000000 (clz=1); 3F800001 + BF800000 -> 34000000 (clz=23).
//  3) 40400000 + C0400000 -> 00000000; 3F800000 + 00000001 (denormal) -> 3F800000.
//  4) 7F7FFFFF + 7F7FFFFF -> 7F800000, ovf=1; 7F800000 + 3F800000 -> 7FC00000, no flags.
//  5) Backpressure: out_ready=0 for 10 cycles -> result stable, in_ready=0; in_valid pulses ignored.
//     Then out_ready=1 -> exactly one transfer.
//  6) rst_n low during NORM -> out_valid=0 immediately; after release, a new pair completes correctly.

Source files
------------

// File: rtl/fp_add_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_seq_pkg
//  Description : Shared definitions for the sequential FP adder: FSM state
//                encoding, exponent saturation limit, quiet-NaN constant and
//                leading-zero counter widths.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_add_seq_pkg;

   // Largest biased exponent; reaching it after normalisation saturates to inf
   localparam int EXP_MAX = 255;

   // Default quiet NaN returned when an operand is inf/NaN
   localparam logic [31:0] QNAN_DEFAULT = 32'h7FC0_0000;

   // Leading-zero counter geometry (24-bit significand, 5-bit count)
   localparam int CLZ_W = 24;
   localparam int LZ_W  = 5;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ALIGN = 3'd1,
      S_ADD   = 3'd2,
      S_NORM  = 3'd3,
      S_PACK  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

endpackage
`default_nettype wire

// File: rtl/fp_add_seq_clz.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_seq_clz
//  Description : Count of leading zeros over a 24-bit significand. An all-zero
//                input reports 24.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_add_seq_clz
   import fp_add_seq_pkg::*;
(
   input  logic [CLZ_W-1:0] din,
   output logic [LZ_W-1:0]  lz
);

   // Scan from the LSB upward so the most significant set bit is the last writer
   always_comb begin
      lz = LZ_W'(CLZ_W);
      for (int i = 0; i < CLZ_W; i++) begin
         if (din[i]) begin
            lz = LZ_W'(CLZ_W - 1 - i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fp_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_seq
//  Description : Multi-cycle single-precision FP adder. One operand pair is
//                accepted, then ALIGN -> ADD -> NORM -> PACK run one stage per
//                cycle and the packed result is offered over valid/ready.
//                Rounding is toward zero; denormal inputs are treated as zero.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_add_seq
   import fp_add_seq_pkg::*;
#(
   parameter int          EXP_W    = 8,
   parameter int          FRAC_W   = 23,
   parameter logic [31:0] QNAN_VAL = QNAN_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [EXP_W+FRAC_W:0]   op_a,
   input  logic [EXP_W+FRAC_W:0]   op_b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [EXP_W+FRAC_W:0]   result,
   output logic                    ovf,
   output logic                    unf
);

   localparam int DW = 1 + EXP_W + FRAC_W;  // packed word width
   localparam int SW = FRAC_W + 1;          // significand incl. hidden bit
   localparam int XW = EXP_W + 2;           // signed working exponent

   localparam logic signed [XW-1:0] EXP_SAT = XW'(EXP_MAX);

   state_t state, next_state;

   // Operand and inter-stage registers
   logic [DW-1:0]          a_reg, b_reg;
   logic                   al_sign, al_sub, al_nan;
   logic [EXP_W-1:0]       al_exp;
   logic [SW-1:0]          al_big, al_small;
   logic [SW:0]            sum_reg;
   logic [FRAC_W-1:0]      nm_frac;
   logic signed [XW-1:0]   nm_exp;
   logic                   nm_zero;

   // Combinational stage results
   logic [EXP_W-1:0]       exp_a, exp_b, exp_diff;
   logic [SW-1:0]          sig_a, sig_b, sig_small, aligned_small;
   logic                   a_big;
   logic [SW:0]            sum_next;
   logic [LZ_W-1:0]        lz;
   logic [FRAC_W-1:0]      norm_frac;
   logic signed [XW-1:0]   norm_exp;
   logic                   norm_zero;
   logic [DW-1:0]          pack_res;
   logic                   pack_ovf, pack_unf;

   // Held low during reset so upstream never sees a spurious ready
   assign in_ready = rst_n && (state == S_IDLE);

   fp_add_seq_clz u_clz (
      .din (sum_reg[SW-1:0]),
      .lz  (lz)
   );

   // ALIGN: flush denormals, order by magnitude, shift smaller significand right
   always_comb begin
      exp_a     = a_reg[DW-2:FRAC_W];
      exp_b     = b_reg[DW-2:FRAC_W];
      sig_a     = (exp_a == '0) ? '0 : {1'b1, a_reg[FRAC_W-1:0]};
      sig_b     = (exp_b == '0) ? '0 : {1'b1, b_reg[FRAC_W-1:0]};
      a_big     = {exp_a, sig_a} >= {exp_b, sig_b};
      exp_diff  = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
      sig_small = a_big ? sig_b : sig_a;
      aligned_small = (exp_diff >= EXP_W'(SW)) ? '0 : (sig_small >> exp_diff);
   end

   // ADD: magnitude add or subtract; ordering guarantees no borrow out
   always_comb begin
      sum_next = al_sub ? ({1'b0, al_big} - {1'b0, al_small})
                        : ({1'b0, al_big} + {1'b0, al_small});
   end

   // NORM: carry shifts right; otherwise left-justify using the clz count
   always_comb begin
      norm_frac = '0;
      norm_exp  = '0;
      norm_zero = 1'b0;
      if (sum_reg[SW]) begin
         norm_frac = sum_reg[SW-1:1];
         norm_exp  = signed'({2'b00, al_exp}) + XW'(1);
      end else if (sum_reg == '0) begin
         norm_zero = 1'b1;
      end else begin
         norm_frac = FRAC_W'(sum_reg[SW-1:0] << lz);
         norm_exp  = signed'({2'b00, al_exp}) - signed'({{(XW-LZ_W){1'b0}}, lz});
      end
   end

   // PACK: specials first, then zero, saturation, flush, normal encoding
   always_comb begin
      pack_res = '0;
      pack_ovf = 1'b0;
      pack_unf = 1'b0;
      if (al_nan) begin
         pack_res = QNAN_VAL;
      end else if (nm_zero) begin
         pack_res = '0;
      end else if (nm_exp >= EXP_SAT) begin
         pack_res = {al_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         pack_ovf = 1'b1;
      end else if (nm_exp <= XW'(0)) begin
         pack_unf = 1'b1;
      end else begin
         pack_res = {al_sign, nm_exp[EXP_W-1:0], nm_frac};
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   // FSM next-state: fixed stage walk, leave DONE only on a completed transfer
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (in_valid) next_state = S_ALIGN;
         S_ALIGN: next_state = S_ADD;
         S_ADD:   next_state = S_NORM;
         S_NORM:  next_state = S_PACK;
         S_PACK:  next_state = S_DONE;
         S_DONE:  if (out_valid && out_ready) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Datapath registers, each stage written only while its state is active
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg    <= '0;
         b_reg    <= '0;
         al_sign  <= 1'b0;
         al_sub   <= 1'b0;
         al_nan   <= 1'b0;
         al_exp   <= '0;
         al_big   <= '0;
         al_small <= '0;
         sum_reg  <= '0;
         nm_frac  <= '0;
         nm_exp   <= '0;
         nm_zero  <= 1'b0;
         result   <= '0;
         ovf      <= 1'b0;
         unf      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_reg <= op_a;
                  b_reg <= op_b;
               end
            end
            S_ALIGN: begin
               al_sign  <= a_big ? a_reg[DW-1] : b_reg[DW-1];
               al_sub   <= a_reg[DW-1] ^ b_reg[DW-1];
               al_nan   <= (&exp_a) | (&exp_b);
               al_exp   <= a_big ? exp_a : exp_b;
               al_big   <= a_big ? sig_a : sig_b;
               al_small <= aligned_small;
            end
            S_ADD: sum_reg <= sum_next;
            S_NORM: begin
               nm_frac <= norm_frac;
               nm_exp  <= norm_exp;
               nm_zero <= norm_zero;
            end
            S_PACK: begin
               result <= pack_res;
               ovf    <= pack_ovf;
               unf    <= pack_unf;
            end
            default: ;
         endcase
      end
   end

   // out_valid is a clean flop: raised one cycle into DONE, dropped on transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 out_valid <= 1'b0;
      else if (state != S_DONE)   out_valid <= 1'b0;
      else if (out_valid && out_ready) out_valid <= 1'b0;
      else                        out_valid <= 1'b1;
   end

endmodule
`default_nettype wire
